// File: rtl/hilo_pipe_if.sv
// E-stage HI/LO write/read signals, pipeline stall/flush controls and the
// forwarded/architectural HI/LO results exchanged with the hilo_pipe unit.
interface hilo_pipe_if;
  logic        we_e;
  logic [63:0] wdata_e;
  logic        rd_e;
  logic        stallE;
  logic        stallM;
  logic        flushM;
  logic        stallW;
  logic        flushW;
  logic [63:0] hilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_stall;

  modport master (
    output we_e, wdata_e, rd_e, stallE, stallM, flushM, stallW, flushW,
    input  hilo_o, hi_o, lo_o, hilo_stall
  );

  modport slave (
    input  we_e, wdata_e, rd_e, stallE, stallM, flushM, stallW, flushW,
    output hilo_o, hi_o, lo_o, hilo_stall
  );
endinterface

// File: rtl/hilo_pipe.sv
// HI/LO register unit: carries E-stage HI/LO writes through M and W, commits in W.
// Define HILO_FWD_EN to forward pending writes to hilo_o; otherwise readers stall.
module hilo_pipe (
  input  logic        clk,
  input  logic        rst,
  hilo_pipe_if.slave  bus
);

  logic        we_m_reg;
  logic [63:0] data_m_reg;
  logic        we_w_reg;
  logic [63:0] data_w_reg;
  logic [63:0] hilo_q_reg;
  logic        commit;

  // M slot: a held E stage injects a bubble rather than duplicating the writer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_m_reg   <= 1'b0;
      data_m_reg <= 64'd0;
    end else if (bus.flushM) begin
      we_m_reg <= 1'b0;
    end else if (bus.stallM) begin
      we_m_reg   <= we_m_reg;
      data_m_reg <= data_m_reg;
    end else if (bus.stallE) begin
      we_m_reg <= 1'b0;
    end else begin
      we_m_reg   <= bus.we_e;
      data_m_reg <= bus.wdata_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_w_reg   <= 1'b0;
      data_w_reg <= 64'd0;
    end else if (bus.flushW) begin
      we_w_reg <= 1'b0;
    end else if (bus.stallW) begin
      we_w_reg   <= we_w_reg;
      data_w_reg <= data_w_reg;
    end else if (bus.stallM) begin
      we_w_reg <= 1'b0;
    end else begin
      we_w_reg   <= we_m_reg;
      data_w_reg <= data_m_reg;
    end
  end

  // A flush in the commit cycle wins, keeping HI/LO precise under exceptions.
  assign commit = we_w_reg & ~bus.stallW & ~bus.flushW;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hilo_q_reg <= 64'd0;
    end else if (commit) begin
      hilo_q_reg <= data_w_reg;
    end
  end

  assign bus.hi_o = hilo_q_reg[63:32];
  assign bus.lo_o = hilo_q_reg[31:0];

`ifdef HILO_FWD_EN
  logic unused_rd_e;
  assign unused_rd_e    = bus.rd_e;
  // Youngest pending writer wins.
  assign bus.hilo_o     = we_m_reg ? data_m_reg :
                          we_w_reg ? data_w_reg : hilo_q_reg;
  assign bus.hilo_stall = 1'b0;
`else
  assign bus.hilo_o     = hilo_q_reg;
  assign bus.hilo_stall = bus.rd_e & (we_m_reg | we_w_reg);
`endif

endmodule

// File: tb/tb_hilo_pipe.sv
// Self-checking bench for hilo_pipe; expected commits flow through a scoreboard queue.
// Works with HILO_FWD_EN defined or undefined.
module tb_hilo_pipe;
`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_pipe_if bus ();

  hilo_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] arch = 64'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_e    = 1'b0;
    bus.wdata_e = 64'd0;
    bus.rd_e    = 1'b0;
    bus.stallE  = 1'b0;
    bus.stallM  = 1'b0;
    bus.flushM  = 1'b0;
    bus.stallW  = 1'b0;
    bus.flushW  = 1'b0;
  endtask

  // Issue MTHI/MTLO like the controller would: hold E while a hazard is flagged,
  // then merge the new half into the value presented on hilo_o.
  task automatic issue_mt(input bit is_hi, input logic [31:0] v, output int n);
    bus.we_e = 1'b1;
    bus.rd_e = 1'b1;
    #1;
    n = 0;
    while (bus.hilo_stall && n < 8) begin
      bus.stallE = 1'b1;
      tick();
      n++;
    end
    bus.stallE  = 1'b0;
    bus.wdata_e = is_hi ? {v, bus.hilo_o[31:0]} : {bus.hilo_o[63:32], v};
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus.rd_e = 1'b1;
    #1;
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin errors++; $display("FAIL reset_arch: got %h want 0", {bus.hi_o, bus.lo_o}); end
    checks++; if (bus.hilo_o !== 64'd0) begin errors++; $display("FAIL reset_hilo_o: got %h want 0", bus.hilo_o); end
    checks++; if (bus.hilo_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.hilo_stall); end
    idle();
    bus.we_e = 1'b1; bus.wdata_e = 64'h1234_5678_9ABC_DEF0; sb_q.push_back(bus.wdata_e);
    tick();
    idle();
    tick();
    tick();
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL reset_load: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    bus.we_e = 1'b1; bus.wdata_e = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    arch = 64'd0;
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL reset_mid: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    checks++; if (bus.hilo_o !== arch) begin errors++; $display("FAIL reset_mid_hilo_o: got %h want %h", bus.hilo_o, arch); end
    tick();
    tick();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL reset_pending_lost: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_reset done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_forward();
    logic [63:0] v;
    int n;
    int edges;
    v = 64'h0000_0001_0000_0002;
    bus.we_e = 1'b1; bus.wdata_e = v; sb_q.push_back(v);
    tick();
    idle();
    bus.rd_e = 1'b1;
    #1;
    checks++; if (bus.hilo_stall !== !FWD) begin errors++; $display("FAIL fwd_first_stall: got %b want %b", bus.hilo_stall, !FWD); end
    checks++; if (bus.hilo_o !== (FWD ? v : arch)) begin errors++; $display("FAIL fwd_m_slot: got %h want %h", bus.hilo_o, FWD ? v : arch); end
    n = 0;
    while (bus.hilo_stall && n < 8) begin
      bus.stallE = 1'b1;
      tick();
      n++;
    end
    checks++; if (n !== (FWD ? 0 : 2)) begin errors++; $display("FAIL fwd_stall_cycles: got %0d want %0d", n, FWD ? 0 : 2); end
    checks++; if (bus.hilo_o !== v) begin errors++; $display("FAIL fwd_read_value: got %h want %h", bus.hilo_o, v); end
    idle();
    edges = 1 + n;
    while (edges < 3) begin
      tick();
      edges++;
    end
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL fwd_commit: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_forward done: stalls=%0d arch=%h", n, {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_mthi_mtlo();
    int n_hi;
    int n_lo;
    sb_q.push_back(64'hAAAA_AAAA_5555_5555);
    issue_mt(1'b1, 32'hAAAA_AAAA, n_hi);
    issue_mt(1'b0, 32'h5555_5555, n_lo);
    checks++; if (n_hi !== 0) begin errors++; $display("FAIL mt_hi_stalls: got %0d want 0", n_hi); end
    checks++; if (n_lo !== (FWD ? 0 : 2)) begin errors++; $display("FAIL mt_lo_stalls: got %0d want %0d", n_lo, FWD ? 0 : 2); end
    tick();
    tick();
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL mt_chain: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_mthi_mtlo done: hi=%h lo=%h", bus.hi_o, bus.lo_o);
  endtask

  task automatic test_flush();
    logic [63:0] v;
    v = 64'hDEAD_BEEF_0000_0000;
    bus.we_e = 1'b1; bus.wdata_e = v; bus.flushM = 1'b1;
    tick();
    idle();
    checks++; if (bus.hilo_o !== arch) begin errors++; $display("FAIL flushm_hilo_o: got %h want %h", bus.hilo_o, arch); end
    tick(); tick(); tick();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL flushm_arch: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    bus.we_e = 1'b1; bus.wdata_e = v;
    tick();
    idle();
    tick();
    checks++; if (bus.hilo_o !== (FWD ? v : arch)) begin errors++; $display("FAIL flushw_pre: got %h want %h", bus.hilo_o, FWD ? v : arch); end
    bus.flushW = 1'b1;
    tick();
    idle();
    checks++; if (bus.hilo_o !== arch) begin errors++; $display("FAIL flushw_hilo_o: got %h want %h", bus.hilo_o, arch); end
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL flushw_no_commit: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    bus.we_e = 1'b1; bus.wdata_e = 64'hDEAD_0001_DEAD_0001;
    tick();
    bus.wdata_e = 64'hDEAD_0002_DEAD_0002;
    tick();
    idle();
    bus.flushM = 1'b1; bus.flushW = 1'b1;
    tick();
    idle();
    checks++; if (bus.hilo_o !== arch) begin errors++; $display("FAIL flush_both_hilo_o: got %h want %h", bus.hilo_o, arch); end
    tick(); tick();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL flush_both_arch: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_flush done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_stall_e();
    logic [63:0] v;
    v = 64'h0000_0007_0000_0003;
    bus.we_e = 1'b1; bus.wdata_e = v; bus.stallE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.hilo_o !== arch) begin errors++; $display("FAIL stalle_bubble%0d: got %h want %h", i, bus.hilo_o, arch); end
    end
    bus.stallE = 1'b0; sb_q.push_back(v);
    tick();
    idle();
    checks++; if (bus.hilo_o !== (FWD ? v : arch)) begin errors++; $display("FAIL stalle_release: got %h want %h", bus.hilo_o, FWD ? v : arch); end
    tick();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stalle_early: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    tick();
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stalle_commit: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_stall_e done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_stall_w();
    logic [63:0] v;
    v = 64'h1111_2222_3333_4444;
    bus.we_e = 1'b1; bus.wdata_e = v; sb_q.push_back(v);
    tick();
    idle();
    tick();
    bus.stallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stallw_hold%0d: got %h want %h", i, {bus.hi_o, bus.lo_o}, arch); end
      checks++; if (bus.hilo_o !== (FWD ? v : arch)) begin errors++; $display("FAIL stallw_fwd%0d: got %h want %h", i, bus.hilo_o, FWD ? v : arch); end
    end
    bus.stallW = 1'b0;
    tick();
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stallw_commit: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_stall_w done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_stall_m();
    logic [63:0] v;
    v = 64'h5555_6666_7777_8888;
    bus.we_e = 1'b1; bus.wdata_e = v; sb_q.push_back(v);
    tick();
    idle();
    bus.stallM = 1'b1;
    tick(); tick();
    checks++; if (bus.hilo_o !== (FWD ? v : arch)) begin errors++; $display("FAIL stallm_hold: got %h want %h", bus.hilo_o, FWD ? v : arch); end
    bus.stallM = 1'b0;
    tick();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stallm_early: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    tick();
    arch = sb_q.pop_front();
    checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL stallm_commit: got %h want %h", {bus.hi_o, bus.lo_o}, arch); end
    $display("test_stall_m done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [3];
    logic [63:0] exp_fwd;
    vals[0] = 64'hA1A1_A1A1_0000_0011;
    vals[1] = 64'hB2B2_B2B2_0000_0022;
    vals[2] = 64'hC3C3_C3C3_0000_0033;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        bus.we_e = 1'b1; bus.wdata_e = vals[i]; sb_q.push_back(vals[i]);
      end else begin
        idle();
      end
      tick();
      if (i >= 2) arch = sb_q.pop_front();
      exp_fwd = FWD ? vals[(i > 2) ? 2 : i] : arch;
      checks++; if (bus.hilo_o !== exp_fwd) begin errors++; $display("FAIL b2b_hilo_o%0d: got %h want %h", i, bus.hilo_o, exp_fwd); end
      checks++; if ({bus.hi_o, bus.lo_o} !== arch) begin errors++; $display("FAIL b2b_arch%0d: got %h want %h", i, {bus.hi_o, bus.lo_o}, arch); end
    end
    idle();
    $display("test_back_to_back done: arch=%h", {bus.hi_o, bus.lo_o});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_mthi_mtlo();
    test_flush();
    test_stall_e();
    test_stall_w();
    test_stall_m();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_pipe.md
# hilo_pipe

HI/LO register unit for the MIPS pipeline. It captures the 64-bit HI/LO result that the execute-stage ALU produces for MULT/MULTU/DIV/DIVU/MTHI/MTLO, carries it through the M and W stages, and commits it architecturally in W. It also supplies the forwarded HI/LO value back to the ALU's `hilo` input, so that MTHI/MTLO merging and MFHI/MFLO always see the youngest committed-or-pending value. Pending writes in M or W are cancelled by pipeline flushes, which keeps HI/LO precise under exceptions.

## Interface
Parameters:
- none (width fixed at 64 bits: HI = [63:32], LO = [31:0])

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- we_e  in  1  E-stage instruction writes HI/LO (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
- wdata_e  in  64  ALU `y` for that instruction, already merged for MTHI/MTLO
- rd_e  in  1  E-stage instruction reads HI/LO (MFHI, MFLO, MTHI, MTLO)
- stallE  in  1  E stage held (div/mul busy); E must not advance into M
- stallM  in  1  M stage held
- flushM  in  1  squash M-stage contents (exception/eret)
- stallW  in  1  W stage held
- flushW  in  1  squash W-stage contents
- hilo_o  out  64  forwarded HI/LO to ALU `hilo` input
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- hilo_stall  out  1  request E-stage stall on HI/LO hazard (always 0 with forwarding)

## Operation
- State: M slot {we_m, data_m}; W slot {we_w, data_w}; architectural register hilo_q[63:0].
- M slot, evaluated each edge in priority order:
  - flushM: we_m <= 0
  - else stallM: hold
  - else stallE: we_m <= 0 (bubble)
  - else we_m <= we_e, data_m <= wdata_e
- W slot, evaluated each edge in priority order:
  - flushW: we_w <= 0
  - else stallW: hold
  - else stallM: we_w <= 0 (bubble)
  - else we_w <= we_m, data_w <= data_m
- Commit: if we_w & ~stallW & ~flushW, hilo_q <= data_w. flushW takes precedence over commit in the same cycle.
- Forwarding (combinational): hilo_o = we_m ? data_m : we_w ? data_w : hilo_q. The youngest writer wins.
- hi_o = hilo_q[63:32]; lo_o = hilo_q[31:0]. These are architectural values only and are never forwarded.
- data_m and data_w are don't-care while their we bit is 0. They are not cleared on flush.

## Timing
- Reset (rst = 0 at an edge): we_m, we_w, data_m, data_w, hilo_q all become 0. As a result hilo_o = 0, hi_o = lo_o = 0, hilo_stall = 0. Reset overrides every other input and takes effect mid-operation; any pending write is lost.
- Write-to-read latency: an instruction in E directly after a writer sees the new value through the M-slot forward. No bubble is required.
- Architectural visibility: the value appears on hi_o/lo_o 2 cycles after the writer leaves E, provided there are no stalls.
- Back-to-back writers (e.g. MTHI then MTLO): the second reads the first's value from the M slot, so its merged word contains both halves.
- While stallE is held, hilo_o is stable unless M or W advance. The multiplier/divider inputs are unaffected.
- Simultaneous flushM and flushW: both slots are emptied and no commit occurs that cycle.

## Configuration
- HILO_FWD_EN defined: forwarding as above; hilo_stall is tied to 0.
- HILO_FWD_EN undefined:
  - hilo_o = hilo_q only.
  - hilo_stall = rd_e & (we_m | we_w), combinational. The controller holds E until both slots are empty.
  - Reader latency after a writer becomes 2 extra cycles.

## Test plan
- Reset: load hilo_q via a commit, then pulse rst = 0 for one edge -> hi_o = lo_o = 0, hilo_o = 0, no commit on the next cycles.
- Forwarding (HILO_FWD_EN): MULT with wdata_e = 64'h0000_0001_0000_0002, then MFHI in the next cycle -> hilo_o = 64'h0000_0001_0000_0002 in that cycle; hi_o = 32'h1 two edges after the MULT leaves E.
- MTHI/MTLO chain: MTHI writes {32'hAAAA_AAAA, lo}, then MTLO writes {hi, 32'h5555_5555} from the forwarded value -> final hi_o = 32'hAAAA_AAAA, lo_o = 32'h5555_5555.
- Flush: writer of 64'hDEAD_BEEF_0000_0000 reaches M, assert flushM -> hi_o/lo_o keep their prior value and hilo_o reverts to hilo_q next cycle. Repeat with flushW in the commit cycle -> no commit.
- Stall/bubble: hold stallE for 5 cycles during DIV, then release with we_e = 1 -> exactly one commit occurs. Hold stallW for 3 cycles -> commit delayed 3 cycles and data_w held.
- No forwarding (HILO_FWD_EN undefined): MULT followed by MFLO -> hilo_stall = 1 for 2 cycles, then 0 with hilo_o = committed value.
